// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - Control and raster-output bundle for vga_timing_gen
//
// Signals:
//   en, resync                              control into the generator
//   pix_ce, hsync, vsync, de, x, y          registered raster outputs
//   line_start, frame_start, vblank_start   one-clk strobes
// Modports:
//   master  the timing generator (drives raster outputs)
//   slave   the controller/renderer (drives en/resync)
interface vga_timing_gen_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           en;
    logic           resync;
    logic           pix_ce;
    logic           hsync;
    logic           vsync;
    logic           de;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           line_start;
    logic           frame_start;
    logic           vblank_start;

    modport master (
        input  en, resync,
        output pix_ce, hsync, vsync, de, x, y,
               line_start, frame_start, vblank_start
    );

    modport slave (
        output en, resync,
        input  pix_ce, hsync, vsync, de, x, y,
               line_start, frame_start, vblank_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - Parametrised VGA raster timing generator
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   vif    vga_timing_gen_if.master: en/resync in; pix_ce, hsync, vsync,
//          de, x, y, line_start, frame_start, vblank_start out (all registered)
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int X_W      = 10,
    parameter int Y_W      = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0]   HS_BEG   = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0]   HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0]   VS_BEG   = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0]   VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [X_W-1:0]   H_ACT    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]   V_ACT    = Y_W'(V_ACTIVE);

    logic [DIV_W-1:0] div_cnt;
    logic [X_W-1:0]   h_cnt;
    logic [Y_W-1:0]   v_cnt;

    logic             pix_ce_q;
    logic             hsync_q;
    logic             vsync_q;
    logic             de_q;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic             line_q;
    logic             frame_q;
    logic             vblank_q;

    // Decode of the pixel currently held in the counters; captured into the
    // output registers on the load, so outputs trail the counters by one pixel.
    logic h_de, v_de, hs_on, vs_on, div_wrap;

    assign h_de     = (h_cnt < H_ACT);
    assign v_de     = (v_cnt < V_ACT);
    assign hs_on    = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_on    = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign div_wrap = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            h_cnt    <= '0;
            v_cnt    <= '0;
            pix_ce_q <= 1'b0;
            hsync_q  <= ~HS_POL;
            vsync_q  <= ~VS_POL;
            de_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
            vblank_q <= 1'b0;
        end else if (vif.resync) begin
            // Restart exactly as after reset, regardless of en.
            div_cnt  <= '0;
            h_cnt    <= '0;
            v_cnt    <= '0;
            pix_ce_q <= 1'b0;
            hsync_q  <= ~HS_POL;
            vsync_q  <= ~VS_POL;
            de_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            if (vif.en) begin
                div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
            end
            pix_ce_q <= vif.en && div_wrap;

            line_q   <= 1'b0;
            frame_q  <= 1'b0;
            vblank_q <= 1'b0;

            // A pending pixel strobe is honoured only while enabled, so a
            // freeze never advances the counters.
            if (pix_ce_q && vif.en) begin
                de_q     <= h_de && v_de;
                hsync_q  <= hs_on ? HS_POL : ~HS_POL;
                vsync_q  <= vs_on ? VS_POL : ~VS_POL;
                x_q      <= h_cnt;
                y_q      <= v_cnt;
                line_q   <= (h_cnt == '0);
                frame_q  <= (h_cnt == '0) && (v_cnt == '0);
                vblank_q <= (h_cnt == '0) && (v_cnt == V_ACT);

                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + Y_W'(1);
                end else begin
                    h_cnt <= h_cnt + X_W'(1);
                end
            end
        end
    end

    assign vif.pix_ce       = pix_ce_q;
    assign vif.hsync        = hsync_q;
    assign vif.vsync        = vsync_q;
    assign vif.de           = de_q;
    assign vif.x            = x_q;
    assign vif.y            = y_q;
    assign vif.line_start   = line_q;
    assign vif.frame_start  = frame_q;
    assign vif.vblank_start = vblank_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - Directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.X_W(10), .Y_W(10)) d_if ();
    vga_timing_gen_if #(.X_W(3),  .Y_W(3))  s_if ();

    vga_timing_gen dut_d (
        .clk   (clk),
        .rst_n (rst_n),
        .vif   (d_if.master)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .X_W(3), .Y_W(3)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .vif   (s_if.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_x(input int xv, input int limit, input string tag);
        int n = 0;
        while (d_if.x !== 10'(xv) && n < limit) begin
            tick();
            n++;
        end
        chk(tag, 32'(d_if.x), 32'(xv));
    endtask

    initial begin
        int n, pc, hs, hmin, hmax, dec, dmax, vsl, viol;
        int ex, ey;

        rst_n = 1'b0;
        d_if.en = 1'b1; d_if.resync = 1'b0;
        s_if.en = 1'b1; s_if.resync = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_pix_ce", 32'(d_if.pix_ce), 0);
        chk("rst_de",     32'(d_if.de), 0);
        chk("rst_x",      32'(d_if.x), 0);
        chk("rst_y",      32'(d_if.y), 0);
        chk("rst_hsync",  32'(d_if.hsync), 1);
        chk("rst_vsync",  32'(d_if.vsync), 1);
        chk("rst_frame",  32'(d_if.frame_start), 0);
        chk("rst_s_hsync", 32'(s_if.hsync), 0);
        chk("rst_s_vsync", 32'(s_if.vsync), 0);

        // First pixel after release: pix_ce on clk 1, outputs on clk 2
        rst_n = 1'b1;
        tick();
        chk("clk0_pix_ce", 32'(d_if.pix_ce), 0);
        tick();
        chk("clk1_pix_ce", 32'(d_if.pix_ce), 1);
        chk("clk1_frame",  32'(d_if.frame_start), 0);
        tick();
        chk("clk2_x",     32'(d_if.x), 0);
        chk("clk2_y",     32'(d_if.y), 0);
        chk("clk2_de",    32'(d_if.de), 1);
        chk("clk2_line",  32'(d_if.line_start), 1);
        chk("clk2_frame", 32'(d_if.frame_start), 1);
        chk("clk2_pix_ce", 32'(d_if.pix_ce), 0);

        // One full line of the default 800-pixel raster
        n = 0; pc = 0; hs = 0; hmin = 9999; hmax = -1; dec = 0; dmax = -1; vsl = 0;
        do begin
            if (d_if.pix_ce) begin
                pc++;
                if (!d_if.hsync) begin
                    hs++;
                    if (int'(d_if.x) < hmin) hmin = int'(d_if.x);
                    if (int'(d_if.x) > hmax) hmax = int'(d_if.x);
                end
                if (d_if.de) begin
                    dec++;
                    if (int'(d_if.x) > dmax) dmax = int'(d_if.x);
                end
            end
            if (!d_if.vsync) vsl++;
            tick();
            n++;
        end while (!d_if.line_start && n < 2000);
        chk("line_period", 32'(n), 1600);
        chk("pix_per_line", 32'(pc), 800);
        chk("hsync_pixels", 32'(hs), 96);
        chk("hsync_first_x", 32'(hmin), 656);
        chk("hsync_last_x", 32'(hmax), 751);
        chk("de_pixels", 32'(dec), 640);
        chk("de_last_x", 32'(dmax), 639);
        chk("vsync_line0", 32'(vsl), 0);
        chk("line1_x", 32'(d_if.x), 0);
        chk("line1_y", 32'(d_if.y), 1);
        chk("line1_frame", 32'(d_if.frame_start), 0);

        // Freeze for 37 clks at x=100
        wait_x(100, 400, "reach_x100");
        d_if.en = 1'b0;
        viol = 0;
        repeat (37) begin
            tick();
            if (d_if.x !== 10'd100 || d_if.y !== 10'd1 || d_if.pix_ce !== 1'b0 ||
                d_if.line_start !== 1'b0 || d_if.hsync !== 1'b1 || d_if.de !== 1'b1)
                viol++;
        end
        chk("en_low_hold", 32'(viol), 0);
        d_if.en = 1'b1;
        tick();
        chk("en_resume_pix_ce", 32'(d_if.pix_ce), 1);
        chk("en_resume_x_hold", 32'(d_if.x), 100);
        tick();
        chk("en_resume_x", 32'(d_if.x), 101);

        // resync mid-line
        wait_x(300, 600, "reach_x300");
        d_if.resync = 1'b1;
        tick();
        d_if.resync = 1'b0;
        chk("resync_x",  32'(d_if.x), 0);
        chk("resync_y",  32'(d_if.y), 0);
        chk("resync_de", 32'(d_if.de), 0);
        chk("resync_hsync", 32'(d_if.hsync), 1);
        chk("resync_pix_ce", 32'(d_if.pix_ce), 0);
        tick();
        tick();
        chk("resync_frame_early", 32'(d_if.frame_start), 0);
        tick();
        chk("resync_frame", 32'(d_if.frame_start), 1);
        chk("resync_first_de", 32'(d_if.de), 1);

        // resync wins over en=0, then generator stays frozen
        d_if.en = 1'b0;
        d_if.resync = 1'b1;
        tick();
        d_if.resync = 1'b0;
        chk("resync_en0_x", 32'(d_if.x), 0);
        chk("resync_en0_de", 32'(d_if.de), 0);
        viol = 0;
        repeat (5) begin
            tick();
            if (d_if.pix_ce !== 1'b0 || d_if.frame_start !== 1'b0 || d_if.de !== 1'b0) viol++;
        end
        chk("resync_en0_frozen", 32'(viol), 0);
        d_if.en = 1'b1;
        tick();
        tick();
        tick();
        chk("resync_en0_restart", 32'(d_if.frame_start), 1);

        // Asynchronous reset during hsync
        wait_x(700, 2000, "reach_x700");
        chk("in_hsync", 32'(d_if.hsync), 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_hsync", 32'(d_if.hsync), 1);
        chk("async_rst_vsync", 32'(d_if.vsync), 1);
        chk("async_rst_de",    32'(d_if.de), 0);
        chk("async_rst_x",     32'(d_if.x), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("rel_frame_early", 32'(d_if.frame_start), 0);
        tick();
        chk("rel_frame", 32'(d_if.frame_start), 1);
        chk("rel_x", 32'(d_if.x), 0);

        // Small raster, CLK_DIV=1, active-high syncs
        s_if.resync = 1'b1;
        tick();
        s_if.resync = 1'b0;
        chk("s_resync_hsync", 32'(s_if.hsync), 0);
        chk("s_resync_x", 32'(s_if.x), 0);
        tick();
        chk("s_pix_ce", 32'(s_if.pix_ce), 1);
        tick();
        for (int i = 0; i < 48; i++) begin
            ex = i % 8;
            ey = i / 8;
            chk($sformatf("s_x_%0d", i), 32'(s_if.x), 32'(ex));
            chk($sformatf("s_y_%0d", i), 32'(s_if.y), 32'(ey));
            chk($sformatf("s_hsync_%0d", i), 32'(s_if.hsync), 32'(ex == 5 || ex == 6));
            chk($sformatf("s_vsync_%0d", i), 32'(s_if.vsync), 32'(ey == 4));
            chk($sformatf("s_de_%0d", i), 32'(s_if.de), 32'(ex < 4 && ey < 3));
            chk($sformatf("s_line_%0d", i), 32'(s_if.line_start), 32'(ex == 0));
            chk($sformatf("s_frame_%0d", i), 32'(s_if.frame_start), 32'(i == 0));
            chk($sformatf("s_vblank_%0d", i), 32'(s_if.vblank_start), 32'(ex == 0 && ey == 3));
            tick();
        end
        chk("s_frame_period", 32'(s_if.frame_start), 1);
        chk("s_wrap_y", 32'(s_if.y), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
